if_stage_unit: RTL and testbench
================================

Name: if_stage_unit

Overview:
- Instruction-fetch stage: owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Consumes the hazard unit's active-low `stall` and the flush unit's `IF_Flush`.
- Takes redirect requests from EX (taken branch) and ID (jump/jr/exception); feeds the ID stage.

Parameters:
RESET_VECTOR, 32'h80000000, PC value loaded on reset
ILLOP_VECTOR, 32'h80000004, PC target for interrupt / illegal-op redirect
XADR_VECTOR, 32'h80000008, PC target for exception redirect
NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on flush

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
stall  input  1  active-low hold from hazard unit: 0 = hold PC and IF/ID, 1 = advance
IF_Flush  input  1  1 = load bubble into IF/ID this cycle
EX_BranchTaken  input  1  branch in EX resolved taken
EX_BranchTarget  input  32  branch target computed in EX
ID_PCSrc  input  3  ID redirect: 0 seq, 1 j/jal, 2 jr/jalr, 3 ILLOP, 4 XADR, 5-7 treated as 0
ID_JumpTarget  input  26  instr_index field of J-type in ID
ID_DatabusA  input  32  rs value for jr/jalr
Instruction  input  32  instruction memory read data for address PC (combinational ROM)
PC  output  32  current fetch address
IF_ID_Instruction  output  32  instruction presented to ID
IF_ID_PC_plus_4  output  32  PC+4 of instruction in ID
IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_VECTOR, IF_ID_Instruction=NOP_WORD, IF_ID_PC_plus_4=0, IF_ID_Valid=0.
  - Release takes effect on the first rising edge with reset=1.
  - Reset asserted mid-operation discards all in-flight state; no partial update.
- PC+4 rule: PC_plus_4 = {PC[31], PC[30:0]+31'd4}.
  - Supervisor bit PC[31] is never changed by sequential increment.
  - Bits [30:0] wrap modulo 2^31.
- Jump target: {PC_plus_4[31:28], ID_JumpTarget, 2'b00}.
- jr target: ID_DatabusA taken verbatim, so bit 31 may clear (kernel exit).
- Next-PC priority, evaluated every edge with reset=1:
  1. EX_BranchTaken=1 -> EX_BranchTarget. Overrides stall=0; the stalled instruction is on the wrong path.
  2. stall=0 -> PC unchanged.
  3. ID_PCSrc 1/2/3/4 -> jump / jr / ILLOP_VECTOR / XADR_VECTOR.
  4. Otherwise -> PC_plus_4.
- IF/ID update priority:
  1. IF_Flush=1 or EX_BranchTaken=1 -> Instruction=NOP_WORD, Valid=0, PC_plus_4 register = PC_plus_4.
  2. stall=0 -> all IF/ID fields hold.
  3. Otherwise -> capture Instruction, PC_plus_4; Valid=1.
- Latency: an instruction fetched at PC in cycle n appears on IF_ID_* in cycle n+1.
- Redirect penalties:
  - ID redirect costs 1 bubble.
  - EX branch costs 2 bubbles: the IF/ID bubble here plus ID_Flush applied by the downstream ID/EX register.
- Stall vs jump in ID: stall=0 with ID_PCSrc!=0 gives no redirect. Jump stays in ID and redirects on the first cycle stall=1, so exactly one redirect is performed.
- Inconsistent inputs (IF_Flush=0 with ID_PCSrc!=0): PC still redirects; IF/ID captures normally. Bench checks the flush unit never produces this.
- PC output is purely the register; no combinational path from inputs to PC.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined:
  - Adds outputs `stall_cnt` [31:0] and `flush_cnt` [31:0], reset to 0.
  - `stall_cnt` increments on each edge with stall=0 and EX_BranchTaken=0.
  - `flush_cnt` increments on each edge where IF/ID loads a bubble.
  - Both saturate at 32'hFFFFFFFF.
- When undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 3 cycles, release -> PC=32'h80000000, then 32'h80000004, 32'h80000008 on successive edges; IF_ID_Valid=0 then 1; IF_ID_PC_plus_4=32'h80000004 after first fetch.
- Stall: stall=0 for 2 cycles at PC=32'h80000010 -> PC and IF_ID_Instruction unchanged both cycles; PC=32'h80000014 on the edge after stall=1.
- Jump: ID_PCSrc=1, ID_JumpTarget=26'h0000040, IF_Flush=1 at PC=32'h00400008 -> next PC=32'h00000100, IF_ID_Instruction=0, IF_ID_Valid=0.
- Branch vs stall: EX_BranchTaken=1, EX_BranchTarget=32'h00400020, stall=0, ID_PCSrc=1 -> PC=32'h00400020, IF/ID bubble; jump ignored.
- jr to user: PC=32'h80000100, ID_PCSrc=2, ID_DatabusA=32'h00400000 -> PC=32'h00400000; then increment to 32'h00400004 with PC[31]=0.
- Async reset mid-stream: assert reset between edges while PC=32'h00400030 -> PC=32'h80000000 immediately, IF_ID_Valid=0. With IF_PERF_CNT_EN: counters=0.

Source files
------------

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and next-PC selection.
// Optional IF_PERF_CNT_EN adds saturating stall/flush event counters.
module if_stage_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter logic [31:0] ILLOP_VECTOR = 32'h80000004,
  parameter logic [31:0] XADR_VECTOR  = 32'h80000008,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        IF_Flush,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchTarget,
  input  logic [2:0]  ID_PCSrc,
  input  logic [25:0] ID_JumpTarget,
  input  logic [31:0] ID_DatabusA,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus_4,
  output logic        IF_ID_Valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] p4_q, p4_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_plus_4;
  logic [31:0] jump_tgt;
  logic        bubble;

  // Supervisor bit is preserved; only the low 31 bits wrap.
  assign pc_plus_4 = {pc_q[31], pc_q[30:0] + 31'd4};
  assign jump_tgt  = {pc_plus_4[31:28], ID_JumpTarget, 2'b00};
  assign bubble    = IF_Flush | EX_BranchTaken;

  always_comb begin
    pc_d = pc_plus_4;
    if (EX_BranchTaken) begin
      pc_d = EX_BranchTarget;
    end else if (!stall) begin
      pc_d = pc_q;
    end else begin
      unique case (ID_PCSrc)
        3'd1:    pc_d = jump_tgt;
        3'd2:    pc_d = ID_DatabusA;
        3'd3:    pc_d = ILLOP_VECTOR;
        3'd4:    pc_d = XADR_VECTOR;
        default: pc_d = pc_plus_4;
      endcase
    end
  end

  always_comb begin
    ins_d = ins_q;
    p4_d  = p4_q;
    vld_d = vld_q;
    if (bubble) begin
      ins_d = NOP_WORD;
      p4_d  = pc_plus_4;
      vld_d = 1'b0;
    end else if (stall) begin
      ins_d = Instruction;
      p4_d  = pc_plus_4;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      ins_q <= NOP_WORD;
      p4_q  <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ins_q <= ins_d;
      p4_q  <= p4_d;
      vld_q <= vld_d;
    end
  end

  assign PC                = pc_q;
  assign IF_ID_Instruction = ins_q;
  assign IF_ID_PC_plus_4   = p4_q;
  assign IF_ID_Valid       = vld_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // A taken branch overrides the hold, so it does not count as a stall cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (!stall && !EX_BranchTaken && (stall_cnt_q != 32'hFFFFFFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bubble && (flush_cnt_q != 32'hFFFFFFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Self-checking bench for if_stage_unit: directed scenarios plus randomized traffic
// against a behavioural fetch model. Define IF_PERF_CNT_EN to also check the counters.
module tb_if_stage_unit;
  localparam logic [31:0] RV  = 32'h80000000;
  localparam logic [31:0] IV  = 32'h80000004;
  localparam logic [31:0] XV  = 32'h80000008;
  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset, stall, IF_Flush, EX_BranchTaken;
  logic [31:0] EX_BranchTarget, ID_DatabusA, Instruction;
  logic [2:0]  ID_PCSrc;
  logic [25:0] ID_JumpTarget;
  logic [31:0] PC, IF_ID_Instruction, IF_ID_PC_plus_4;
  logic        IF_ID_Valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_vld;
  longint      m_sc, m_fc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign Instruction = rom(PC);

  if_stage_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .IF_Flush(IF_Flush),
    .EX_BranchTaken(EX_BranchTaken), .EX_BranchTarget(EX_BranchTarget),
    .ID_PCSrc(ID_PCSrc), .ID_JumpTarget(ID_JumpTarget), .ID_DatabusA(ID_DatabusA),
    .Instruction(Instruction), .PC(PC), .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PC_plus_4(IF_ID_PC_plus_4), .IF_ID_Valid(IF_ID_Valid)
`ifdef IF_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_ins = NOP; m_p4 = 32'h0; m_vld = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  task automatic drive(input logic st, input logic fl, input logic bt, input logic [31:0] btgt,
                       input logic [2:0] src, input logic [25:0] jt, input logic [31:0] da);
    stall = st; IF_Flush = fl; EX_BranchTaken = bt; EX_BranchTarget = btgt;
    ID_PCSrc = src; ID_JumpTarget = jt; ID_DatabusA = da;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pc"},  PC, m_pc);
    check_val({tag, ".ins"}, IF_ID_Instruction, m_ins);
    check_val({tag, ".p4"},  IF_ID_PC_plus_4, m_p4);
    check_val({tag, ".vld"}, {31'b0, IF_ID_Valid}, {31'b0, m_vld});
`ifdef IF_PERF_CNT_EN
    check_val({tag, ".scnt"}, stall_cnt, (m_sc > 64'hFFFFFFFF) ? 32'hFFFFFFFF : m_sc[31:0]);
    check_val({tag, ".fcnt"}, flush_cnt, (m_fc > 64'hFFFFFFFF) ? 32'hFFFFFFFF : m_fc[31:0]);
`endif
  endtask

  // One clock edge: predict from the rules, advance, compare.
  task automatic step(input string tag);
    logic [31:0] seq, nxt;
    logic [31:0] n_ins, n_p4;
    logic        n_vld;
    check_val({tag, ".pc_pre"}, PC, m_pc);
    seq = m_pc + 32'd4;
    seq[31] = m_pc[31];
    if (EX_BranchTaken)  nxt = EX_BranchTarget;
    else if (!stall)     nxt = m_pc;
    else if (ID_PCSrc == 3'd1) nxt = {seq[31:28], ID_JumpTarget, 2'b00};
    else if (ID_PCSrc == 3'd2) nxt = ID_DatabusA;
    else if (ID_PCSrc == 3'd3) nxt = IV;
    else if (ID_PCSrc == 3'd4) nxt = XV;
    else                 nxt = seq;
    n_ins = m_ins; n_p4 = m_p4; n_vld = m_vld;
    if (IF_Flush || EX_BranchTaken) begin
      n_ins = NOP; n_p4 = seq; n_vld = 1'b0; m_fc++;
    end else if (stall) begin
      n_ins = rom(m_pc); n_p4 = seq; n_vld = 1'b1;
    end
    if (!stall && !EX_BranchTaken) m_sc++;
    @(posedge clk); #1;
    m_pc = nxt; m_ins = n_ins; m_p4 = n_p4; m_vld = n_vld;
    check_all(tag);
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    drive(1'b1, 1'b0, 1'b1, tgt, 3'd0, 26'h0, 32'h0);
    step("br");
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 26'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 26'h0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    check_val("rst.pc_lit", PC, 32'h80000000);

    @(negedge clk); reset = 1'b1;
    step("rel1");
    check_val("rel1.pc_lit", PC, 32'h80000004);
    check_val("rel1.vld_lit", {31'b0, IF_ID_Valid}, 32'd1);
    check_val("rel1.p4_lit", IF_ID_PC_plus_4, 32'h80000004);
    step("rel2");
    check_val("rel2.pc_lit", PC, 32'h80000008);

    // Stall holds PC and IF/ID
    branch_to(32'h80000010);
    idle(); step("pre_st");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 26'h0, 32'h0);
    step("st1");
    step("st2");
    idle(); step("st_rel");

    branch_to(32'h80000010);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 26'h0, 32'h0);
    step("st3");
    check_val("st3.pc_lit", PC, 32'h80000010);
    idle(); step("st4");
    check_val("st4.pc_lit", PC, 32'h80000014);

    // Jump in ID with flush
    branch_to(32'h00400008);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 3'd1, 26'h0000040, 32'h0);
    step("jmp");
    check_val("jmp.pc_lit", PC, 32'h00000100);
    check_val("jmp.vld_lit", {31'b0, IF_ID_Valid}, 32'd0);

    // Stalled jump waits, then redirects once
    branch_to(32'h00400040);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd1, 26'h0000080, 32'h0);
    step("sjmp0");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 3'd1, 26'h0000080, 32'h0);
    step("sjmp1");
    check_val("sjmp1.pc_lit", PC, 32'h00000200);

    // Taken branch overrides stall and jump
    drive(1'b0, 1'b1, 1'b1, 32'h00400020, 3'd1, 26'h0000040, 32'h0);
    step("bvs");
    check_val("bvs.pc_lit", PC, 32'h00400020);
    check_val("bvs.vld_lit", {31'b0, IF_ID_Valid}, 32'd0);

    // jr exits kernel, increments without regaining bit 31
    branch_to(32'h80000100);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 3'd2, 26'h0, 32'h00400000);
    step("jr");
    check_val("jr.pc_lit", PC, 32'h00400000);
    idle(); step("jr_seq");
    check_val("jr_seq.pc_lit", PC, 32'h00400004);

    // ILLOP / XADR vectors, and out-of-range PCSrc acts sequential
    drive(1'b1, 1'b1, 1'b0, 32'h0, 3'd3, 26'h0, 32'h0); step("illop");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 3'd4, 26'h0, 32'h0); step("xadr");
    drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd6, 26'h0, 32'h0); step("src6");

    // Low 31 bits wrap, bit 31 preserved
    branch_to(32'hFFFFFFFC);
    idle(); step("wrap_k");
    check_val("wrap_k.pc_lit", PC, 32'h80000000);
    branch_to(32'h7FFFFFFC);
    idle(); step("wrap_u");
    check_val("wrap_u.pc_lit", PC, 32'h00000000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic st, fl, bt;
      logic [2:0] src;
      st  = ($urandom_range(0, 3) != 0);
      bt  = ($urandom_range(0, 7) == 0);
      src = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      fl  = (src != 3'd0) || ($urandom_range(0, 15) == 0);
      drive(st, fl, bt, $urandom, src, 26'($urandom), $urandom);
      step("rnd");
    end

    // Asynchronous reset between edges
    branch_to(32'h00400030);
    idle();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    check_val("arst.pc_lit", PC, 32'h80000000);
    repeat (2) @(posedge clk);
    #1;
    check_all("arst_hold");
    @(negedge clk); reset = 1'b1;
    step("arst_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
